// File: rtl/iter_alu_if.sv
// Request/response bundle for the iterative execute ALU.
// The master side (core) drives requests and result back-pressure;
// the slave side (ALU) drives readiness, the result and busy.
interface iter_alu_if #(
  parameter int XLEN = 32
);
  logic            inValid;
  logic            inReady;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic [4:0]      opSel;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output inValid, srcA, srcB, opSel, outReady,
    input  inReady, outValid, result, busy
  );

  modport slave (
    input  inValid, srcA, srcB, opSel, outReady,
    output inReady, outValid, result, busy
  );
endinterface

// File: rtl/iter_alu.sv
// Handshaked execute ALU: RV32I ops with one registered cycle of latency,
// RV32M ops via a 1 bit/cycle shift-add multiplier and restoring divider.
// Iterations run on operand magnitudes; signs are reapplied on the last step.
module iter_alu #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic       clk,
  input logic       rst,
  iter_alu_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_a;       // multiplicand or divisor magnitude
  logic [XLEN-1:0] r_hi;      // product high half / partial remainder
  logic [XLEN-1:0] r_lo;      // multiplier bits / dividend-quotient shifter
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;      // opSel[1:0] of the iterating op
  logic            r_negQ;    // negate product / quotient at the end
  logic            r_negR;    // negate remainder at the end

  logic            w_accept;
  logic [CW-1:0]   w_shamt;
  logic [XLEN-1:0] w_base;
  logic            w_aSigned, w_bSigned, w_aNeg, w_bNeg;
  logic [XLEN-1:0] w_aMag, w_bMag;
  logic            w_divZero, w_ovf, w_fast;
  logic [XLEN-1:0] w_fastRes;
  logic [XLEN:0]   w_madd;
  logic [XLEN-1:0] w_mhi, w_mlo;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;
  logic            w_qbit;
  logic [XLEN-1:0] w_dhi, w_dlo;
  logic [2*XLEN-1:0] w_prod, w_sprod;
  logic [XLEN-1:0] w_mres, w_q, w_r, w_dres;

  assign bus.inReady  = (r_state == IDLE) || (r_state == HOLD && bus.outReady);
  assign bus.outValid = (r_state == HOLD);
  assign bus.busy     = (r_state == MUL) || (r_state == DIV);
  assign bus.result   = r_result;

  assign w_accept = bus.inValid && bus.inReady;
  assign w_shamt  = bus.srcB[CW-1:0];

  // Single-cycle base-op result, also the default for unlisted codes (pass A)
  always_comb begin
    w_base = bus.srcA;
    case (bus.opSel[3:0])
      4'b0000: w_base = bus.srcA + bus.srcB;
      4'b0001: w_base = bus.srcA << w_shamt;
      4'b0010: w_base = {{(XLEN-1){1'b0}}, $signed(bus.srcA) < $signed(bus.srcB)};
      4'b0011: w_base = {{(XLEN-1){1'b0}}, bus.srcA < bus.srcB};
      4'b0100: w_base = bus.srcA ^ bus.srcB;
      4'b0101: w_base = bus.srcA >> w_shamt;
      4'b0110: w_base = bus.srcA | bus.srcB;
      4'b0111: w_base = bus.srcA & bus.srcB;
      4'b1100: w_base = bus.srcA - bus.srcB;
      4'b1101: w_base = $signed(bus.srcA) >>> w_shamt;
      4'b1111: w_base = bus.srcB;
      default: w_base = bus.srcA;
    endcase
  end

  // Operand signedness: mulh/mulhsu/div/rem treat A as signed, mulh/div/rem B
  assign w_aSigned = (bus.opSel[2:0] == 3'b001) || (bus.opSel[2:0] == 3'b010) ||
                     (bus.opSel[2:0] == 3'b100) || (bus.opSel[2:0] == 3'b110);
  assign w_bSigned = (bus.opSel[2:0] == 3'b001) || (bus.opSel[2:0] == 3'b100) ||
                     (bus.opSel[2:0] == 3'b110);
  assign w_aNeg    = w_aSigned && bus.srcA[XLEN-1];
  assign w_bNeg    = w_bSigned && bus.srcB[XLEN-1];
  assign w_aMag    = w_aNeg ? -bus.srcA : bus.srcA;
  assign w_bMag    = w_bNeg ? -bus.srcB : bus.srcB;

  // Divide-by-zero and signed overflow resolve without iterating
  assign w_divZero = (bus.srcB == '0);
  assign w_ovf     = (bus.opSel[2:0] == 3'b100 || bus.opSel[2:0] == 3'b110) &&
                     (bus.srcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.srcB == '1);
  assign w_fast    = bus.opSel[2] && (w_divZero || w_ovf);
  assign w_fastRes = w_divZero ? (bus.opSel[1] ? bus.srcA : '1)
                               : (bus.opSel[1] ? '0 : bus.srcA);

  // One shift-add step: add multiplicand on low bit, shift the pair right
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mhi  = w_madd[XLEN:1];
  assign w_mlo  = {w_madd[0], r_lo[XLEN-1:1]};

  // One restoring step: subtract divisor from shifted remainder if it fits.
  // When it fits the difference is below the divisor, so XLEN bits suffice.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_qbit  = (w_shift >= {1'b0, r_a});
  assign w_sub   = w_shift[XLEN-1:0] - r_a;
  assign w_dhi   = w_qbit ? w_sub : w_shift[XLEN-1:0];
  assign w_dlo   = {r_lo[XLEN-2:0], w_qbit};

  // Final result from the last step's values
  assign w_prod  = {w_mhi, w_mlo};
  assign w_sprod = r_negQ ? -w_prod : w_prod;
  assign w_mres  = (r_op == 2'b00) ? w_sprod[XLEN-1:0] : w_sprod[2*XLEN-1:XLEN];
  assign w_q     = r_negQ ? -w_dlo : w_dlo;
  assign w_r     = r_negR ? -w_dhi : w_dhi;
  assign w_dres  = r_op[1] ? w_r : w_q;

  // Control FSM and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
    end else if (w_accept) begin
      if (bus.opSel[4] && ENABLE_M) begin
        if (w_fast) begin
          r_result <= w_fastRes;
          r_state  <= HOLD;
        end else begin
          r_op   <= bus.opSel[1:0];
          r_negQ <= w_aNeg ^ w_bNeg;
          r_negR <= w_aNeg;
          r_cnt  <= '0;
          r_hi   <= '0;
          if (bus.opSel[2]) begin
            r_lo    <= w_aMag;
            r_a     <= w_bMag;
            r_state <= DIV;
          end else begin
            r_lo    <= w_bMag;
            r_a     <= w_aMag;
            r_state <= MUL;
          end
        end
      end else begin
        r_result <= bus.opSel[4] ? '0 : w_base;
        r_state  <= HOLD;
      end
    end else begin
      case (r_state)
        MUL: begin
          r_hi  <= w_mhi;
          r_lo  <= w_mlo;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN-1)) begin
            r_result <= w_mres;
            r_state  <= HOLD;
          end
        end
        DIV: begin
          r_hi  <= w_dhi;
          r_lo  <= w_dlo;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN-1)) begin
            r_result <= w_dres;
            r_state  <= HOLD;
          end
        end
        HOLD: if (bus.outReady) r_state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: the driver pushes the reference result,
// latency and busy length at accept; the monitor pops on outValid&&outReady.
module tb_iter_alu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iter_alu_if #(.XLEN(32)) bus ();
  iter_alu #(.XLEN(32), .ENABLE_M(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          bsy;
    int          acc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rand_mode = 1'b0;
  logic man_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  // Reference model from the ISA definitions using 64-bit arithmetic
  function automatic exp_t model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint sa, sb, ub, p;
    longint unsigned ua, uub, pu;
    logic [4:0] sh;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a}; uub = {32'b0, b}; ub = longint'(uub);
    sh = b[4:0];
    e.lat = 1; e.bsy = 0; e.acc = 0; e.name = "";
    e.exp = a;
    if (!op[4]) begin
      case (op[3:0])
        4'b0000: e.exp = a + b;
        4'b0001: e.exp = a << sh;
        4'b0010: e.exp = (sa < sb) ? 32'd1 : 32'd0;
        4'b0011: e.exp = (ua < uub) ? 32'd1 : 32'd0;
        4'b0100: e.exp = a ^ b;
        4'b0101: e.exp = a >> sh;
        4'b0110: e.exp = a | b;
        4'b0111: e.exp = a & b;
        4'b1100: e.exp = a - b;
        4'b1101: begin p = sa >>> sh; e.exp = p[31:0]; end
        4'b1111: e.exp = b;
        default: e.exp = a;
      endcase
    end else begin
      e.lat = 33; e.bsy = 32;
      case (op[2:0])
        3'b000: begin p = sa * sb; e.exp = p[31:0]; end
        3'b001: begin p = sa * sb; e.exp = p[63:32]; end
        3'b010: begin p = sa * ub; e.exp = p[63:32]; end
        3'b011: begin pu = ua * uub; e.exp = pu[63:32]; end
        3'b100: if (b == 0) e.exp = 32'hFFFFFFFF; else begin p = sa / sb; e.exp = p[31:0]; end
        3'b101: if (b == 0) e.exp = 32'hFFFFFFFF; else begin pu = ua / uub; e.exp = pu[31:0]; end
        3'b110: if (b == 0) e.exp = a; else begin p = sa % sb; e.exp = p[31:0]; end
        default: if (b == 0) e.exp = a; else begin pu = ua % uub; e.exp = pu[31:0]; end
      endcase
      if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) begin
        e.lat = 1; e.bsy = 0;
      end
    end
    return e;
  endfunction

  // Present a request until accepted; returns how many cycles it was offered
  task automatic issue(logic [4:0] op, logic [31:0] a, logic [31:0] b, string nm,
                       output int tries);
    exp_t e;
    e = model(op, a, b);
    e.name = nm;
    bus.opSel = op; bus.srcA = a; bus.srcB = b; bus.inValid = 1'b1;
    tries = 0;
    forever begin
      @(negedge clk);
      tries++;
      if (bus.inReady) begin
        e.acc = cyc;
        q.push_back(e);
        break;
      end
      if (tries > 300) begin
        checks++; errors++;
        $display("FAIL accept_timeout %s: not accepted after %0d cycles", nm, tries);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.inValid = 1'b0;
    bus.srcA = $urandom; bus.srcB = $urandom; bus.opSel = 5'($urandom);
  endtask

  task automatic go(logic [4:0] op, logic [31:0] a, logic [31:0] b, string nm);
    int t;
    issue(op, a, b, nm, t);
  endtask

  task automatic drain(int max);
    for (int t = 0; t <= max; t++) begin
      if (q.size() == 0) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: %0d results still pending", q.size());
  endtask

  // outReady source: manual value or random back-pressure
  initial begin
    bus.outReady = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.outReady = rand_mode ? ($urandom_range(0, 3) != 0) : man_ready;
    end
  end

  // Monitor: latency and busy length on first outValid, result every valid cycle
  initial begin
    int  bcnt;
    logic seen;
    bcnt = 0; seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0; seen = 1'b0;
      end else begin
        if (bus.busy) bcnt++;
        if (bus.outValid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_outValid: result %h with nothing pending", bus.result);
          end else begin
            if (!seen) begin
              chk({q[0].name, "_lat"}, 32'(cyc - q[0].acc), 32'(q[0].lat));
              chk({q[0].name, "_busy"}, 32'(bcnt), 32'(q[0].bsy));
              seen = 1'b1;
            end
            chk(q[0].name, bus.result, q[0].exp);
            if (bus.outReady) begin
              void'(q.pop_front());
              seen = 1'b0;
              bcnt = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.inValid = 1'b0; bus.srcA = '0; bus.srcB = '0; bus.opSel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.result, 32'h0);
    chk("rst_outValid", {31'b0, bus.outValid}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inReady", {31'b0, bus.inReady}, 32'h1);
    @(posedge clk); #1;

    // Base ops
    go(5'b00000, 32'h7FFFFFFF, 32'h1,        "add_ovf");
    go(5'b01101, 32'h80000000, 32'h4,        "sra");
    go(5'b00011, 32'h1,        32'hFFFFFFFF, "sltu");
    go(5'b00010, 32'h1,        32'hFFFFFFFF, "slt");
    go(5'b00001, 32'h1,        32'd33,       "sll_33");
    go(5'b01100, 32'h5,        32'h7,        "sub");
    go(5'b01111, 32'h1234,     32'hABCD,     "passB");
    go(5'b01000, 32'h1234,     32'hABCD,     "passA");
    // Multiply
    go(5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul");
    go(5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh");
    go(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
    go(5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    go(5'b11000, 32'd12345,    32'd6789,     "mul_op3");
    // Divide
    go(5'b10100, 32'hFFFFFFF9, 32'h2,        "div_neg");
    go(5'b10110, 32'hFFFFFFF9, 32'h2,        "rem_neg");
    go(5'b10101, 32'd100,      32'd7,        "divu");
    go(5'b10111, 32'd100,      32'd7,        "remu");
    // Fast paths
    go(5'b10100, 32'd5,        32'd0,        "div_by0");
    go(5'b10110, 32'd5,        32'd0,        "rem_by0");
    go(5'b10100, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    go(5'b10110, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");
    drain(100);

    // Back-pressure: result held, no new accept, then same-cycle handoff
    man_ready = 1'b0;
    go(5'b00000, 32'd40, 32'd2, "bp_add");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_outValid", {31'b0, bus.outValid}, 32'h1);
      chk("bp_inReady", {31'b0, bus.inReady}, 32'h0);
    end
    @(posedge clk); #1;
    man_ready = 1'b1;
    issue(5'b00100, 32'hF0F0F0F0, 32'h0FF00FF0, "bp_xor", t);
    chk("bp_same_cycle_accept", 32'(t), 32'd1);
    drain(100);

    // Async reset during a multiply
    go(5'b10000, 32'd1000, 32'd1000, "mul_killed");
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_result", bus.result, 32'h0);
    chk("mid_rst_outValid", {31'b0, bus.outValid}, 32'h0);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_inReady", {31'b0, bus.inReady}, 32'h1);
    repeat (40) @(posedge clk);
    #1;
    go(5'b00000, 32'd21, 32'd21, "post_rst_add");
    drain(100);

    // Randomised ops with random back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      go(5'($urandom), a, b, "rand");
    end
    rand_mode = 1'b0;
    man_ready = 1'b1;
    drain(200);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU.
- Executes RV32I integer ops with 1-cycle registered latency.
- Adds RV32M multiply/divide/remainder via an iterative shift-add multiplier and a restoring divider (1 bit/cycle).
- Sits in the execute stage; the core stalls on inReady low and consumes results on outValid/outReady.

Parameters:
- XLEN, 32, operand/result width (power of two, >=8); shift amount is srcB[$clog2(XLEN)-1:0].
- ENABLE_M, 1, 1 = M-extension ops implemented; 0 = M ops return 0 with 1-cycle latency.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- inValid  input  1  operation request
- inReady  output  1  block can accept a request this cycle
- srcA  input  XLEN  operand A (rs1 / pc)
- srcB  input  XLEN  operand B (rs2 / imm)
- opSel  input  5  operation select (encoding below)
- outValid  output  1  result valid
- outReady  input  1  consumer accepts result
- result  output  XLEN  registered result
- busy  output  1  mul/div iteration in progress

Behaviour:
- Encoding, opSel[4]=0:
  - 0000 add, 0001 sll, 0010 slt (signed), 0011 sltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1100 sub, 1101 sra (arithmetic, sign-filling), 1111 pass srcB.
  - All other codes pass srcA.
  - slt/sltu result is zero-extended 0/1.
- Encoding, opSel[4]=1: opSel[2:0] is 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu; opSel[3] is ignored.
- Accept occurs when inValid && inReady. srcA, srcB and opSel are captured at accept; later input changes are ignored.
- FSM states: IDLE, MUL, DIV, HOLD.
  - IDLE: on accept of a base op, or a div fast-path case → HOLD next cycle (outValid at accept+1).
  - IDLE: on accept of mul* → MUL; on accept of div*/rem* → DIV.
  - MUL: runs XLEN iterations on the magnitudes of the operands (signedness per op), producing a 2*XLEN product; the sign is applied at the end. → HOLD after XLEN cycles (outValid at accept+XLEN+1).
  - DIV: runs a restoring division for XLEN iterations on the magnitudes. Quotient sign = sign(A) xor sign(B) for signed ops; remainder takes the sign of the dividend. → HOLD after XLEN cycles (outValid at accept+XLEN+1).
  - HOLD: outValid=1 and result is stable until outReady. On outReady → IDLE, or accepts a new request in the same cycle.
- Result selection: mul returns the low XLEN bits; mulh/mulhsu/mulhu return the high XLEN bits.
- Fast paths (1-cycle latency, no iteration):
  - Divisor 0: div/divu → all ones; rem/remu → srcA.
  - Signed overflow (srcA = most negative, srcB = -1): div → most negative; rem → 0.
- inReady = (state==IDLE) || (state==HOLD && outReady).
- busy = state is MUL or DIV.
- outValid = (state==HOLD).
- Reset values: state IDLE, result 0, outValid 0, busy 0, inReady 1 (after reset release), all iteration registers 0.
- Reset mid-operation: the in-flight op is discarded with no output produced, and the FSM returns to IDLE.
- Back-pressure: in HOLD with outReady low, the block holds indefinitely; inReady stays 0 and result does not change.
- A request with inValid high while inReady is low is neither accepted nor lost. The requester must hold it.
- ENABLE_M=0: M ops take the base-op path and return 0.

Test Plan:
- Base ops, XLEN=32, outReady=1: add 0x7FFFFFFF+1 → 0x80000000 at accept+1; sra 0x80000000 by 4 → 0xF8000000; sltu 1 vs 0xFFFFFFFF → 1; slt same operands → 0; sll uses only srcB[4:0] (shift 33 → shift 1).
- mul 0xFFFFFFFF × 0xFFFFFFFF: mul → 0x00000001, mulh → 0x00000000, mulhu → 0xFFFFFFFE, mulhsu → 0xFFFFFFFF. outValid first at accept+33; busy high for exactly 32 cycles.
- div -7/2 → 0xFFFFFFFD; rem → 0xFFFFFFFF; divu 100/7 → 14; remu → 2. Each with latency 33.
- Fast paths: div 5/0 → 0xFFFFFFFF at accept+1; rem 5/0 → 5; div 0x80000000/-1 → 0x80000000; rem → 0.
- Back-pressure: hold outReady=0 for 5 cycles in HOLD → result stable, inReady=0. Then pulse outReady with inValid=1 → new op accepted in the same cycle, and its result appears next cycle.
- Assert rst at cycle 10 of a mul → outputs 0 immediately (async), inReady=1 after release, no stale outValid; then a new add completes correctly.
